// File: rtl/event_source_latch_pkg.sv
// Shared constants for the event source latch: CPU data width and the event-count ceiling.
package event_source_latch_pkg;

    localparam int EVENT_DATA_W  = 16;
    localparam int EVENT_MAX_NUM = 16;

    // Mask with the low n bits set, n in 1..EVENT_MAX_NUM.
    function automatic logic [EVENT_DATA_W-1:0] low_ones(input int n);
        logic [31:0] v;
        v = (32'h1 << n) - 32'h1;
        return v[EVENT_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/event_source_latch_edge_sync.sv
// One event line: SYNC_STAGES-flop synchronizer plus a previous-value flop.
// Emits a single-cycle pulse on a synchronized rising edge; no backpressure.
module event_source_latch_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Reset clears the chain, so an input held high through reset reads as a new edge.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/event_source_latch.sv
// Latches synchronized peripheral edges as pending levels until CPU ack; raw_in to event_signals is SYNC_STAGES+1 cycles.
// Optional sticky overrun flags when EVENT_SOURCE_OVERRUN_EN is defined; otherwise overrun_out reads zero.
module event_source_latch
    import event_source_latch_pkg::*;
#(
    parameter int NUM_EVENTS  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sysclk,
    input  logic                    sysreset,
    input  logic [NUM_EVENTS-1:0]   raw_in,
    input  logic                    ack_load,
    input  logic                    mask_load,
    input  logic [EVENT_DATA_W-1:0] data_in,
    output logic [NUM_EVENTS-1:0]   event_signals,
    output logic [EVENT_DATA_W-1:0] pending_out,
    output logic [EVENT_DATA_W-1:0] mask_out,
    output logic [EVENT_DATA_W-1:0] overrun_out
);

    logic [NUM_EVENTS-1:0] w_rise;
    logic [NUM_EVENTS-1:0] w_ack;
    logic [NUM_EVENTS-1:0] w_hit;
    logic [NUM_EVENTS-1:0] r_pending;
    logic [NUM_EVENTS-1:0] r_mask;
    logic                  w_unused_data;
    logic [EVENT_DATA_W-1:0] w_mask_rst;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_sync
            event_source_latch_edge_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .i_clk  (sysclk),
                .i_rst  (sysreset),
                .i_raw  (raw_in[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_unused_data = ^data_in;
    assign w_mask_rst    = low_ones(NUM_EVENTS);
    assign w_ack         = ack_load ? data_in[NUM_EVENTS-1:0] : '0;
    assign w_hit         = w_rise & r_mask;

    // Set term is OR'd after the clear so a same-cycle edge is never lost to an ack.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_pending <= '0;
            r_mask    <= w_mask_rst[NUM_EVENTS-1:0];
        end else begin
            r_pending <= (r_pending & ~w_ack) | w_hit;
            if (mask_load) begin
                r_mask <= data_in[NUM_EVENTS-1:0];
            end
        end
    end

    assign event_signals = r_pending;

    always_comb begin
        pending_out                 = '0;
        pending_out[NUM_EVENTS-1:0] = r_pending;
        mask_out                    = '0;
        mask_out[NUM_EVENTS-1:0]    = r_mask;
    end

`ifdef EVENT_SOURCE_OVERRUN_EN
    logic [NUM_EVENTS-1:0] r_overrun;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= (r_overrun & ~w_ack) | (w_hit & r_pending & ~w_ack);
        end
    end

    always_comb begin
        overrun_out                 = '0;
        overrun_out[NUM_EVENTS-1:0] = r_overrun;
    end
`else
    assign overrun_out = 16'h0000;
`endif

endmodule

// File: tb/tb_event_source_latch.sv
// Bench for event_source_latch: directed literal checks plus randomized traffic against a delay-line reference model.
module tb_event_source_latch;

    localparam int N = 6;
    localparam int S = 2;

    logic          sysclk = 1'b0;
    logic          sysreset;
    logic [N-1:0]  raw_in;
    logic          ack_load;
    logic          mask_load;
    logic [15:0]   data_in;
    logic [N-1:0]  event_signals;
    logic [15:0]   pending_out;
    logic [15:0]   mask_out;
    logic [15:0]   overrun_out;

    int n_checks = 0;
    int n_errors = 0;

    event_source_latch #(
        .NUM_EVENTS  (N),
        .SYNC_STAGES (S)
    ) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .raw_in        (raw_in),
        .ack_load      (ack_load),
        .mask_load     (mask_load),
        .data_in       (data_in),
        .event_signals (event_signals),
        .pending_out   (pending_out),
        .mask_out      (mask_out),
        .overrun_out   (overrun_out)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: m_hist[d] holds raw_in as sampled d+1 clock edges ago.
    logic [N-1:0] m_hist [0:S];
    logic [N-1:0] m_pend, m_mask, m_ovr;
    logic [N-1:0] m_ev, m_ack, m_hit;

    always @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            m_pend = '0;
            m_ovr  = '0;
            m_mask = '1;
            for (int d = 0; d <= S; d++) m_hist[d] = '0;
        end else begin
            m_ev  = m_hist[S-1] & ~m_hist[S];
            m_ack = ack_load ? data_in[N-1:0] : '0;
            m_hit = m_ev & m_mask;
`ifdef EVENT_SOURCE_OVERRUN_EN
            m_ovr = (m_ovr & ~m_ack) | (m_hit & m_pend & ~m_ack);
`else
            m_ovr = '0;
`endif
            m_pend = (m_pend & ~m_ack) | m_hit;
            if (mask_load) m_mask = data_in[N-1:0];
            for (int d = S; d >= 1; d--) m_hist[d] = m_hist[d-1];
            m_hist[0] = raw_in;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sysclk) begin
        chk("model_event_signals", {10'd0, event_signals}, {10'd0, m_pend});
        chk("model_pending_out",   pending_out,            {10'd0, m_pend});
        chk("model_mask_out",      mask_out,               {10'd0, m_mask});
        chk("model_overrun_out",   overrun_out,            {10'd0, m_ovr});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        raw_in = v;
        tick(1);
        raw_in = '0;
    endtask

    task automatic cpu_ack(input logic [15:0] d);
        ack_load = 1'b1;
        data_in  = d;
        tick(1);
        ack_load = 1'b0;
        data_in  = '0;
    endtask

    logic [15:0] exp_ovr;

    initial begin
        sysreset  = 1'b1;
        raw_in    = '0;
        ack_load  = 1'b0;
        mask_load = 1'b0;
        data_in   = '0;
        tick(3);
        chk("reset_events",  {10'd0, event_signals}, 16'h0000);
        chk("reset_pending", pending_out, 16'h0000);
        chk("reset_mask",    mask_out,    16'h003F);
        chk("reset_overrun", overrun_out, 16'h0000);
        sysreset = 1'b0;
        tick(2);

        // Single pulse: three-cycle latency
        pulse(6'b000100);
        tick(1);
        chk("t1_not_yet", {10'd0, event_signals}, 16'h0000);
        tick(1);
        chk("t1_events",  {10'd0, event_signals}, 16'h0004);
        chk("t1_pending", pending_out, 16'h0004);

        // Ack clears; ack of out-of-range bits has no effect
        cpu_ack(16'h0004);
        chk("t2_acked", {10'd0, event_signals}, 16'h0000);
        pulse(6'b000100);
        tick(2);
        cpu_ack(16'hFFC0);
        chk("t2_upper_ack", pending_out, 16'h0004);
        cpu_ack(16'h0004);

        // Masked edge dropped, unmasked edge captured
        mask_load = 1'b1; data_in = 16'h003E;
        tick(1);
        mask_load = 1'b0; data_in = '0;
        chk("t3_mask", mask_out, 16'h003E);
        pulse(6'b000001);
        tick(3);
        chk("t3_masked", {10'd0, event_signals}, 16'h0000);
        pulse(6'b000010);
        tick(2);
        chk("t3_unmasked", {10'd0, event_signals}, 16'h0002);
        ack_load = 1'b1; mask_load = 1'b1; data_in = 16'h003F;
        tick(1);
        ack_load = 1'b0; mask_load = 1'b0; data_in = '0;
        chk("t3_both_loads", pending_out | mask_out, 16'h003F);

        // Edge and ack on the same bit in the same cycle
        pulse(6'b100000);
        tick(2);
        chk("t4_first", pending_out, 16'h0020);
        pulse(6'b100000);
        tick(1);
        cpu_ack(16'h0020);
        chk("t4_set_wins", pending_out, 16'h0020);
        chk("t4_no_overrun", overrun_out, 16'h0000);
        cpu_ack(16'h0020);

        // Overrun
        pulse(6'b001000);
        tick(2);
        pulse(6'b001000);
        tick(3);
`ifdef EVENT_SOURCE_OVERRUN_EN
        exp_ovr = 16'h0008;
`else
        exp_ovr = 16'h0000;
`endif
        chk("t5_overrun", overrun_out, exp_ovr);
        chk("t5_pending", pending_out, 16'h0008);
        cpu_ack(16'h0008);
        chk("t5_ack_pending", pending_out, 16'h0000);
        chk("t5_ack_overrun", overrun_out, 16'h0000);

        // Input held high through reset release
        sysreset = 1'b1;
        raw_in   = 6'h3F;
        tick(2);
        sysreset = 1'b0;
        tick(2);
        chk("t6_not_yet", {10'd0, event_signals}, 16'h0000);
        tick(1);
        chk("t6_events", {10'd0, event_signals}, 16'h003F);
        cpu_ack(16'h003F);
        tick(4);
        chk("t6_held_once", {10'd0, event_signals}, 16'h0000);
        raw_in = '0;
        tick(3);

        // Asynchronous reset mid-run
        pulse(6'h3F);
        tick(2);
        mask_load = 1'b1; data_in = 16'h0005;
        tick(1);
        mask_load = 1'b0; data_in = '0;
        sysreset = 1'b1;
        #1;
        chk("t6_rst_events",  {10'd0, event_signals}, 16'h0000);
        chk("t6_rst_pending", pending_out, 16'h0000);
        chk("t6_rst_mask",    mask_out,    16'h003F);
        chk("t6_rst_overrun", overrun_out, 16'h0000);
        tick(1);
        sysreset = 1'b0;
        tick(1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            raw_in    = N'($urandom & $urandom);
            ack_load  = ($urandom_range(0, 3) == 0);
            mask_load = ($urandom_range(0, 15) == 0);
            data_in   = 16'($urandom);
            sysreset  = ($urandom_range(0, 399) == 0);
            tick(1);
            sysreset  = 1'b0;
        end
        raw_in = '0; ack_load = 1'b0; mask_load = 1'b0; data_in = '0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
